// File: rtl/fill_readout_pkg.sv
// Shared types and word packing for the fill readout sequencer.
// Header = {tag, fill, sample count}; trailer = {tag, timeout flag, 7'b0, xor fold}.
package fill_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        CAPTURE,
        TRAILER,
        DONE
    } state_t;

    localparam logic [7:0] HDR_TAG_DEF  = 8'hA5;
    localparam logic [7:0] TRL_TAG_DEF  = 8'h5A;
    localparam int         TAG_LSB      = 24;
    localparam int         HDR_FILL_LSB = 16;
    localparam int         TRL_TMO_BIT  = 23;

    function automatic logic [31:0] pack_hdr(input logic [7:0]  tag,
                                             input logic [7:0]  fill,
                                             input logic [15:0] nsamp);
        logic [31:0] w;
        w                       = '0;
        w[TAG_LSB +: 8]         = tag;
        w[HDR_FILL_LSB +: 8]    = fill;
        w[15:0]                 = nsamp;
        return w;
    endfunction

    function automatic logic [31:0] pack_trl(input logic [7:0]  tag,
                                             input logic        tmo,
                                             input logic [15:0] fold);
        logic [31:0] w;
        w                 = '0;
        w[TAG_LSB +: 8]   = tag;
        w[TRL_TMO_BIT]    = tmo;
        w[15:0]           = fold;
        return w;
    endfunction

endpackage

// File: rtl/fill_readout_sequencer_xor_fold_accum.sv
// 32-bit running XOR of accepted samples, folded to 16 bits; clear wins over enable.
// Fold is combinational from the accumulator, valid the cycle after the last enable.
module xor_fold_accum (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [15:0] fold
);

    logic [31:0] acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

    assign fold = acc[31:16] ^ acc[15:0];

endmodule

// File: rtl/fill_readout_sequencer.sv
// Streams header, NUM_SAMPLES pass-through samples and trailer per go edge; header one cycle after go.
// Header/trailer held until outReady; samples pass straight through with sampleReady = outReady.
module fill_readout_sequencer
    import fill_readout_pkg::*;
#(
    parameter int         NUM_SAMPLES = 1024,
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [7:0] HDR_TAG     = HDR_TAG_DEF,
    parameter logic [7:0] TRL_TAG     = TRL_TAG_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [7:0]  fillNum,
    output logic        done,
    output logic        busy,
    input  logic [31:0] sampleData,
    input  logic        sampleValid,
    output logic        sampleReady,
    output logic [31:0] outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        missedGo,
    output logic        timedOut
);

    localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0]     NS16     = 16'(NUM_SAMPLES);
    localparam logic [15:0]     LAST_IDX = 16'(NUM_SAMPLES - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t         state, state_nxt;
    logic           go_prev;
    logic           go_rise;
    logic           start;
    logic           xfer;
    logic           tmo_hit;
    logic [7:0]     fill;
    logic [15:0]    count;
    logic [TW-1:0]  tmo_cnt;
    logic           tmo;
    logic [15:0]    fold;

    assign go_rise  = go & ~go_prev;
    assign start    = (state == IDLE) && go_rise;
    assign xfer     = (state == CAPTURE) && sampleValid && outReady;
    // A starved cycle can never also be a transfer, so a transfer always beats the limit.
    assign tmo_hit  = (state == CAPTURE) && !sampleValid && (tmo_cnt == TMO_LAST);
    assign busy     = (state != IDLE);
    assign missedGo = go_rise && (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            go_prev  <= 1'b0;
            fill     <= '0;
            count    <= '0;
            tmo_cnt  <= '0;
            tmo      <= 1'b0;
            timedOut <= 1'b0;
        end else begin
            state    <= state_nxt;
            go_prev  <= go;
            timedOut <= tmo_hit;
            if (start) begin
                fill    <= fillNum;
                count   <= '0;
                tmo_cnt <= '0;
                tmo     <= 1'b0;
            end else if (xfer) begin
                count   <= count + 16'd1;
                tmo_cnt <= '0;
            end else if ((state == CAPTURE) && !sampleValid) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if (tmo_hit) begin
                    tmo <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        outValid    = 1'b0;
        outData     = '0;
        sampleReady = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (go_rise) state_nxt = HEADER;
            end
            HEADER: begin
                outValid = 1'b1;
                outData  = pack_hdr(HDR_TAG, fill, NS16);
                if (outReady) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                outValid    = sampleValid;
                outData     = sampleData;
                sampleReady = outReady;
                if ((xfer && (count == LAST_IDX)) || tmo_hit) state_nxt = TRAILER;
            end
            TRAILER: begin
                outValid = 1'b1;
                outData  = pack_trl(TRL_TAG, tmo, fold);
                if (outReady) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    xor_fold_accum u_xor (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (xfer),
        .din   (sampleData),
        .fold  (fold)
    );

endmodule

// File: tb/tb_fill_readout_sequencer.sv
// Randomized bench for fill_readout_sequencer (NUM_SAMPLES=4, TIMEOUT_CYC=16) against a frame-level model.
module tb_fill_readout_sequencer;

    localparam int NS  = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic [7:0]  fillNum = '0;
    logic [31:0] sampleData = '0;
    logic        sampleValid = 1'b0;
    logic        outReady = 1'b0;
    logic        done, busy, sampleReady, outValid, missedGo, timedOut;
    logic [31:0] outData;

    fill_readout_sequencer #(
        .NUM_SAMPLES (NS),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .fillNum     (fillNum),
        .done        (done),
        .busy        (busy),
        .sampleData  (sampleData),
        .sampleValid (sampleValid),
        .sampleReady (sampleReady),
        .outData     (outData),
        .outValid    (outValid),
        .outReady    (outReady),
        .missedGo    (missedGo),
        .timedOut    (timedOut)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Sample source and sink, both updated just after each rising edge.
    logic [31:0] src_q[$];
    int          gap_max = 0;
    int          gap_cnt = 0;
    int          ready_pct = 100;
    bit          src_took = 1'b0;
    int          cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            sampleValid = 1'b0;
            gap_cnt     = 0;
        end else begin
            if (sampleValid && src_took) sampleValid = 1'b0;
            if (!sampleValid && src_q.size() > 0) begin
                if (gap_cnt > 0) begin
                    gap_cnt--;
                end else begin
                    sampleData  = src_q.pop_front();
                    sampleValid = 1'b1;
                    gap_cnt     = $urandom_range(0, gap_max);
                end
            end
        end
        outReady = ($urandom_range(0, 99) < ready_pct);
    end

    // Monitor: collects accepted words, counts pulses, checks stall stability.
    logic [31:0] got_q[$];
    int          done_cnt = 0, tmo_seen = 0, missed_cnt = 0, last_acc_cyc = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_stall = 1'b0;
            src_took   = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", 32'(outValid), 32'd1);
                check("hold_dat", outData, prev_data);
            end
            prev_stall = outValid && !outReady;
            prev_data  = outData;
            if (outValid && outReady) begin
                got_q.push_back(outData);
                last_acc_cyc = cyc;
            end
            src_took = sampleValid && sampleReady;
            if (done) begin
                done_cnt++;
                check("done_lat", 32'(cyc - last_acc_cyc), 32'd1);
                check("done_quiet", 32'({outValid, sampleReady}), 32'd0);
            end
            if (timedOut) tmo_seen++;
            if (missedGo) missed_cnt++;
        end
    end

    logic [31:0] exp_q[$];

    // One fill: build the expected frame from the sample list, run it, compare.
    task automatic run_fill(input logic [7:0] f, input int nsend, input int rpct,
                            input int gmax, input bit mid_go, input bit seq);
        logic [31:0] s[$];
        logic [31:0] x;
        bit          to;
        int          k, d0, t0, m0, wait_n;
        got_q.delete();
        exp_q.delete();
        ready_pct = rpct;
        gap_max   = gmax;
        for (int i = 0; i < nsend; i++) s.push_back(seq ? 32'(i + 1) : $urandom);
        k  = (nsend < NS) ? nsend : NS;
        to = (nsend < NS);
        x  = '0;
        exp_q.push_back({8'hA5, f, 16'(NS)});
        for (int i = 0; i < k; i++) begin
            exp_q.push_back(s[i]);
            x = x ^ s[i];
        end
        exp_q.push_back({8'h5A, to, 7'b0, x[31:16] ^ x[15:0]});
        d0 = done_cnt; t0 = tmo_seen; m0 = missed_cnt;
        @(posedge clk); #1 go = 1'b0;
        foreach (s[i]) src_q.push_back(s[i]);
        @(posedge clk); #1 go = 1'b1; fillNum = f;
        @(negedge clk);
        check("idle_at_go", 32'({busy, outValid}), 32'd0);
        @(negedge clk);
        check("hdr_vld", 32'(outValid), 32'd1);
        check("hdr_dat", outData, exp_q[0]);
        if (mid_go) begin
            repeat (2) @(posedge clk);
            #1 go = 1'b0;
            @(posedge clk);
            #1 go = 1'b1;
        end
        wait_n = 0;
        while (done_cnt == d0 && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        repeat (3) @(negedge clk);
        check("nwords", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("word%0d", i), got_q[i], exp_q[i]);
        check("tmo_pulse", 32'(tmo_seen - t0), 32'(to));
        check("missed_go", 32'(missed_cnt - m0), 32'(mid_go));
        check("src_drained", 32'(src_q.size()) + 32'(sampleValid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n, d0, nw;
        // Reset in idle
        #2 reset = 1'b1;
        #1;
        check("rst_outs", 32'({done, busy, sampleReady, outValid, missedGo, timedOut}), 32'd0);
        check("rst_dat", outData, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs_clk", 32'({done, busy, sampleReady, outValid, missedGo, timedOut}), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_quiet", 32'({busy, outValid, done}), 32'd0);
        check("idle_words", 32'(got_q.size()), 32'd0);

        // Basic frame, always ready
        run_fill(8'h03, 4, 100, 0, 1'b0, 1'b1);
        check("basic_trl", got_q[got_q.size() - 1], 32'h5A000004);

        // Held go across done must not restart
        nw = got_q.size();
        repeat (8) @(negedge clk);
        check("held_go_busy", 32'(busy), 32'd0);
        check("held_go_words", 32'(got_q.size()), 32'(nw));

        // Random backpressure
        run_fill(8'h03, 4, 50, 0, 1'b0, 1'b1);

        // Starvation timeout after two samples
        run_fill(8'h03, 2, 100, 0, 1'b0, 1'b1);
        check("tmo_trl", got_q[got_q.size() - 1], 32'h5A800003);

        // go edge mid-capture
        run_fill(8'h44, 4, 100, 3, 1'b1, 1'b0);

        // Reset during capture
        @(posedge clk); #1 go = 1'b0;
        ready_pct = 100; gap_max = 0;
        for (int i = 0; i < NS; i++) src_q.push_back($urandom);
        @(posedge clk); #1 go = 1'b1; fillNum = 8'h99;
        repeat (2) @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("cap_busy", 32'({busy, sampleReady}), 32'd3);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("rst_cap", 32'({outValid, sampleReady, busy}), 32'd0);
        src_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; go = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_nodone", 32'(done_cnt - d0), 32'd0);
        check("rst_idle", 32'(busy), 32'd0);
        run_fill(8'hC7, 4, 100, 0, 1'b0, 1'b0);

        // Randomized fills, some starving into timeout
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(0, 7);
            if (n > NS) n = NS;
            run_fill(8'($urandom), n, $urandom_range(30, 100), $urandom_range(0, 4), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
